// File: rtl/interconn_pkg.sv
// Shared types and default sizing for the MVU crossbar interconnect.
package interconn_pkg;

   localparam int unsigned N_DEF      = 8;
   localparam int unsigned W_DEF      = 64;
   localparam int unsigned BADDR_DEF  = 15;
   localparam int unsigned BRADDR_DEF = 15;
   localparam int unsigned BLEN_DEF   = 15;
   localparam int unsigned RDLAT_DEF  = 2;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } tx_state_e;

endpackage

// File: rtl/interconn_tx_pipe.sv
// Delay line tracking in-flight local reads: valid, remote address and a last-word marker.
module interconn_tx_pipe #(
   parameter int unsigned Depth = 2,
   parameter int unsigned AW    = 15
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic          out_last,
   output logic [AW-1:0] out_addr,
   output logic          empty
);

   logic [Depth-1:0] vld_q;
   logic [Depth-1:0] last_q;
   logic [AW-1:0]    addr_q [Depth];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         vld_q  <= '0;
         last_q <= '0;
         for (int i = 0; i < Depth; i++) addr_q[i] <= '0;
      end else begin
         vld_q[0]  <= in_valid;
         last_q[0] <= in_last;
         addr_q[0] <= in_addr;
         for (int i = 1; i < Depth; i++) begin
            vld_q[i]  <= vld_q[i-1];
            last_q[i] <= last_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[Depth-1];
   assign out_last  = last_q[Depth-1];
   assign out_addr  = addr_q[Depth-1];
   assign empty     = ~|vld_q;

endmodule

// File: rtl/interconn_tx.sv
// Per-MVU crossbar transmit engine: streams local memory words to a multicast destination set.
// Optional INTERCONN_TX_STATS_EN adds a saturating stat_words count of sent words.
module interconn_tx
   import interconn_pkg::*;
#(
   parameter int unsigned N      = N_DEF,
   parameter int unsigned W      = W_DEF,
   parameter int unsigned BADDR  = BADDR_DEF,
   parameter int unsigned BRADDR = BRADDR_DEF,
   parameter int unsigned BLEN   = BLEN_DEF,
   parameter int unsigned RDLAT  = RDLAT_DEF
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [N-1:0]      cmd_dest,
   input  logic [BRADDR-1:0] cmd_src_addr,
   input  logic [BADDR-1:0]  cmd_dst_addr,
   input  logic [BLEN-1:0]   cmd_len,
   input  logic              hold,
   output logic              mem_rd_en,
   output logic [BRADDR-1:0] mem_rd_addr,
   input  logic [W-1:0]      mem_rd_word,
   output logic [N-1:0]      send_to,
   output logic              send_en,
   output logic [BADDR-1:0]  send_addr,
   output logic [W-1:0]      send_word,
`ifdef INTERCONN_TX_STATS_EN
   output logic [31:0]       stat_words,
`endif
   output logic              busy,
   output logic              done
);

   tx_state_e         state_q, state_d;
   logic [N-1:0]      dest_q;
   logic [BRADDR-1:0] src_q;
   logic [BADDR-1:0]  dst_q;
   logic [BLEN-1:0]   len_q;
   logic [BLEN-1:0]   cnt_q;

   logic             accept, degen, issue, last_issue;
   logic             pipe_valid, pipe_last, pipe_empty;
   logic [BADDR-1:0] pipe_addr;

   assign cmd_ready   = (state_q == StIdle);
   assign accept      = cmd_valid && cmd_ready;
   assign degen       = (cmd_len == '0) || (cmd_dest == '0);
   assign issue       = (state_q == StRun) && !hold;
   assign last_issue  = issue && (cnt_q == len_q - BLEN'(1));
   assign mem_rd_en   = issue;
   assign mem_rd_addr = issue ? src_q + BRADDR'(cnt_q) : '0;
   // done is registered alongside the final send, so it also covers that last cycle
   assign busy        = (state_q != StIdle) || done;

   interconn_tx_pipe #(
      .Depth (RDLAT),
      .AW    (BADDR)
   ) u_pipe (
      .clk       (clk),
      .clr_n     (clr_n),
      .in_valid  (issue),
      .in_last   (last_issue),
      .in_addr   (dst_q + BADDR'(cnt_q)),
      .out_valid (pipe_valid),
      .out_last  (pipe_last),
      .out_addr  (pipe_addr),
      .empty     (pipe_empty)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept && !degen) state_d = StRun;
         StRun:   if (last_issue) state_d = StDrain;
         StDrain: if (pipe_empty) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= StIdle;
         dest_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         send_en   <= 1'b0;
         send_to   <= '0;
         send_addr <= '0;
         send_word <= '0;
         done      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            dest_q <= cmd_dest;
            src_q  <= cmd_src_addr;
            dst_q  <= cmd_dst_addr;
            len_q  <= cmd_len;
            cnt_q  <= '0;
         end else if (issue) begin
            cnt_q <= cnt_q + BLEN'(1);
         end
         send_en   <= pipe_valid;
         send_to   <= pipe_valid ? dest_q : '0;
         send_addr <= pipe_valid ? pipe_addr : '0;
         send_word <= pipe_valid ? mem_rd_word : '0;
         done      <= (accept && degen) || (pipe_valid && pipe_last);
      end
   end

`ifdef INTERCONN_TX_STATS_EN
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         stat_words <= '0;
      end else if (send_en && (stat_words != '1)) begin
         stat_words <= stat_words + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_interconn_tx.sv
// Self-checking bench for interconn_tx: directed scenarios plus randomized commands vs a cycle model.
module tb_interconn_tx;

   localparam int N      = 8;
   localparam int W      = 64;
   localparam int BADDR  = 15;
   localparam int BRADDR = 15;
   localparam int BLEN   = 15;
   localparam int RDLAT  = 2;
   localparam logic [63:0] MULT = 64'h9E3779B97F4A7C15;

   logic              clk, clr_n;
   logic              cmd_valid, cmd_ready;
   logic [N-1:0]      cmd_dest;
   logic [BRADDR-1:0] cmd_src_addr;
   logic [BADDR-1:0]  cmd_dst_addr;
   logic [BLEN-1:0]   cmd_len;
   logic              hold;
   logic              mem_rd_en;
   logic [BRADDR-1:0] mem_rd_addr;
   logic [W-1:0]      mem_rd_word;
   logic [N-1:0]      send_to;
   logic              send_en;
   logic [BADDR-1:0]  send_addr;
   logic [W-1:0]      send_word;
   logic              busy, done;
`ifdef INTERCONN_TX_STATS_EN
   logic [31:0]       stat_words;
`endif

   interconn_tx #(
      .N(N), .W(W), .BADDR(BADDR), .BRADDR(BRADDR), .BLEN(BLEN), .RDLAT(RDLAT)
   ) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_dest     (cmd_dest),
      .cmd_src_addr (cmd_src_addr),
      .cmd_dst_addr (cmd_dst_addr),
      .cmd_len      (cmd_len),
      .hold         (hold),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_word  (mem_rd_word),
      .send_to      (send_to),
      .send_en      (send_en),
      .send_addr    (send_addr),
      .send_word    (send_word),
`ifdef INTERCONN_TX_STATS_EN
      .stat_words   (stat_words),
`endif
      .busy         (busy),
      .done         (done)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int idle_bad = 0;
   logic data_mode = 1'b0;

   typedef struct {
      int               cyc;
      logic [N-1:0]     to;
      logic [BADDR-1:0] addr;
      logic [W-1:0]     word;
   } send_t;

   int                rd_cyc[$];
   logic [BRADDR-1:0] rd_addr[$];
   send_t             send_log[$];
   int                done_cyc[$];
   logic              done_busy[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] word_of(input logic [BRADDR-1:0] a);
      return data_mode ? (64'(a) * MULT) : 64'(a);
   endfunction

   // Memory: returns word_of(address) RDLAT cycles after the read
   logic [BRADDR-1:0] mq[RDLAT];
   always @(posedge clk) begin
      mq[0] <= mem_rd_addr;
      for (int i = 1; i < RDLAT; i++) mq[i] <= mq[i-1];
   end
   always @* mem_rd_word = data_mode ? (64'(mq[RDLAT-1]) * MULT) : 64'(mq[RDLAT-1]);

   always @(negedge clk) begin
      if (clr_n) begin
         if (mem_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(mem_rd_addr);
         end
         if (send_en) send_log.push_back('{cyc, send_to, send_addr, send_word});
         else if (send_to != '0 || send_addr != '0 || send_word != '0) idle_bad++;
         if (done) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy);
         end
      end
   end

   task automatic clear_logs();
      rd_cyc.delete(); rd_addr.delete(); send_log.delete();
      done_cyc.delete(); done_busy.delete(); idle_bad = 0;
   endtask

   // Issues one command, runs it to completion and checks it against the reference model.
   task automatic run_cmd(input logic [N-1:0] dest, input logic [BRADDR-1:0] src,
                          input logic [BADDR-1:0] dst, input logic [BLEN-1:0] len,
                          input logic [63:0] hmask, output int c, output int dcyc);
      int e_rd_cyc[$];
      logic [BRADDR-1:0] e_rd_addr[$];
      logic deg;
      int n, k, e_done;
      bit finished;
      clear_logs();
      deg = (len == 0) || (dest == 0);
      @(posedge clk); #1;
      c = cyc;
      n_chk++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_before_cmd: got %0b, expected 1", cmd_ready);
      end
      cmd_dest = dest; cmd_src_addr = src; cmd_dst_addr = dst; cmd_len = len;
      cmd_valid = 1'b1; hold = 1'b0;
      finished = 0;
      for (int kk = 1; kk < 200; kk++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         hold = (kk < 64) ? hmask[kk] : 1'b0;
         if (kk == 1) begin
            n_chk++;
            if (cmd_ready !== deg) begin
               n_fail++; $display("FAIL ready_after_accept: got %0b, expected %0b", cmd_ready, deg);
            end
         end
         if (done_cyc.size() > 0 && cyc == done_cyc[0] + 1) begin
            n_chk++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL ready_after_done: got ready=%0b busy=%0b, expected ready=1 busy=0",
                        cmd_ready, busy);
            end
            finished = 1;
            break;
         end
      end
      hold = 1'b0;
      n_chk++;
      if (!finished) begin
         n_fail++; $display("FAIL done_timeout: got no done, expected done within budget");
      end
      // Model: reads go out in every unheld cycle after acceptance until len words issued
      n = 0; k = 1;
      while (!deg && n < int'(len)) begin
         if (!(k < 64 && hmask[k])) begin
            e_rd_cyc.push_back(c + k);
            e_rd_addr.push_back(src + BRADDR'(n));
            n++;
         end
         k++;
      end
      e_done = deg ? c + 1 : e_rd_cyc[e_rd_cyc.size()-1] + RDLAT + 1;
      dcyc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      n_chk++;
      if (rd_cyc.size() != e_rd_cyc.size() || send_log.size() != e_rd_cyc.size()) begin
         n_fail++;
         $display("FAIL word_counts: got reads=%0d sends=%0d, expected %0d each",
                  rd_cyc.size(), send_log.size(), e_rd_cyc.size());
      end else begin
         for (int i = 0; i < e_rd_cyc.size(); i++) begin
            n_chk++;
            if (rd_cyc[i] != e_rd_cyc[i] || rd_addr[i] !== e_rd_addr[i]) begin
               n_fail++;
               $display("FAIL read[%0d]: got cyc=%0d addr=%h, expected cyc=%0d addr=%h",
                        i, rd_cyc[i] - c, rd_addr[i], e_rd_cyc[i] - c, e_rd_addr[i]);
            end
            n_chk++;
            if (send_log[i].cyc != e_rd_cyc[i] + RDLAT + 1 || send_log[i].to !== dest ||
                send_log[i].addr !== dst + BADDR'(i) ||
                send_log[i].word !== word_of(src + BRADDR'(i))) begin
               n_fail++;
               $display("FAIL send[%0d]: got cyc=%0d to=%h addr=%h word=%h, expected cyc=%0d to=%h addr=%h word=%h",
                        i, send_log[i].cyc - c, send_log[i].to, send_log[i].addr, send_log[i].word,
                        e_rd_cyc[i] + RDLAT + 1 - c, dest, dst + BADDR'(i), word_of(src + BRADDR'(i)));
            end
         end
      end
      n_chk++;
      if (done_cyc.size() != 1 || dcyc != e_done || done_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL done_pulse: got count=%0d cyc=%0d, expected count=1 cyc=%0d busy=1",
                  done_cyc.size(), dcyc - c, e_done - c);
      end
      n_chk++;
      if (idle_bad != 0) begin
         n_fail++; $display("FAIL idle_send_zero: got %0d nonzero idle cycles, expected 0", idle_bad);
      end
   endtask

   task automatic check_quiet(input string name);
      n_chk++;
      if ({mem_rd_en, mem_rd_addr, send_to, send_en, send_addr, send_word, busy, done} !== '0 ||
          cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: got rd_en=%0b rd_addr=%h send_en=%0b to=%h busy=%0b done=%0b ready=%0b, expected all 0 and ready=1",
                  name, mem_rd_en, mem_rd_addr, send_en, send_to, busy, done, cmd_ready);
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0; cmd_valid = 1'b0; cmd_dest = '0; cmd_src_addr = '0;
      cmd_dst_addr = '0; cmd_len = '0; hold = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_quiet("reset_held");
      @(negedge clk) clr_n = 1'b1;
      @(posedge clk); #1 check_quiet("reset_released");
   endtask

   task automatic test_multicast();
      int c, d;
      data_mode = 1'b0;
      run_cmd(8'h81, 15'h010, 15'h200, 15'd4, 64'd0, c, d);
      n_chk++;
      if (send_log.size() == 0 || send_log[0].cyc - c != 4 || d - c != 7) begin
         n_fail++; $display("FAIL multicast_timing: got done at c+%0d, expected c+7", d - c);
      end
   endtask

   task automatic test_hold();
      int c, d;
      run_cmd(8'h81, 15'h010, 15'h200, 15'd4, 64'b1100, c, d);
      n_chk++;
      if (d - c != 9) begin
         n_fail++; $display("FAIL hold_done: got c+%0d, expected c+9", d - c);
      end
   endtask

   task automatic test_degenerate();
      int c, d;
      run_cmd(8'h81, 15'h010, 15'h200, 15'd0, 64'd0, c, d);
      run_cmd(8'h00, 15'h010, 15'h200, 15'd3, 64'd0, c, d);
   endtask

   task automatic test_wrap();
      int c, d;
      run_cmd(8'h04, 15'h7FFF, 15'h7FFE, 15'd4, 64'd0, c, d);
   endtask

   task automatic test_reset_mid();
      int c, d;
      bit hit;
      clear_logs();
      @(posedge clk); #1;
      cmd_dest = 8'h12; cmd_src_addr = 15'h100; cmd_dst_addr = 15'h040; cmd_len = 15'd8;
      cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      hit = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (send_log.size() >= 2) begin hit = 1; break; end
      end
      n_chk++;
      if (!hit) begin
         n_fail++; $display("FAIL midreset_setup: got %0d sends, expected 2", send_log.size());
      end
      #1 clr_n = 1'b0;
      done_cyc.delete();
      #1 check_quiet("midreset_immediate");
      repeat (2) @(posedge clk);
      @(negedge clk) clr_n = 1'b1;
      repeat (10) @(posedge clk);
      n_chk++;
      if (done_cyc.size() != 0) begin
         n_fail++; $display("FAIL midreset_no_done: got %0d done pulses, expected 0", done_cyc.size());
      end
      run_cmd(8'h30, 15'h222, 15'h111, 15'd2, 64'd0, c, d);
   endtask

   task automatic test_random();
      int c, d;
      data_mode = 1'b1;
      for (int i = 0; i < 25; i++) begin
         run_cmd(N'($urandom), BRADDR'($urandom), BADDR'($urandom), BLEN'($urandom_range(0, 12)),
                 {$urandom, $urandom} & {$urandom, $urandom}, c, d);
      end
   endtask

   task automatic test_back_to_back();
      int c, d;
      data_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_cmd(8'h01 << i, BRADDR'(16 * i), BADDR'(100 * i), BLEN'(i + 1), 64'd0, c, d);
      end
   endtask

   initial begin
      test_reset();
      test_multicast();
      test_hold();
      test_degenerate();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/interconn_tx.md
# interconn_tx

Per-MVU transmit engine for the MVU crossbar interconnect. It accepts a block-transfer command, reads consecutive words from the MVU's local data memory through a fixed-latency read port, and drives that MVU's send port on the crossbar (`send_to`, `send_en`, `send_addr`, `send_word`). Destinations are given as a mask, so one command can multicast. One instance sits between each MVU's memory and its crossbar source port.

## Interface
- `N`, 8: number of MVUs; width of the destination mask.
- `W`, 64: data word width.
- `BADDR`, 15: remote (destination) address width.
- `BRADDR`, 15: local read address width.
- `BLEN`, 15: transfer length width, in words.
- `RDLAT`, 2: local memory read latency in cycles; must be at least 1.

- `clk`, in, 1: clock.
- `clr_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: engine can accept a command.
- `cmd_dest`, in, N: destination MVU mask.
- `cmd_src_addr`, in, BRADDR: local start address.
- `cmd_dst_addr`, in, BADDR: remote start address.
- `cmd_len`, in, BLEN: word count.
- `hold`, in, 1: pause issuing new reads.
- `mem_rd_en`, out, 1: read strobe.
- `mem_rd_addr`, out, BRADDR: read address.
- `mem_rd_word`, in, W: read data, valid RDLAT cycles after `mem_rd_en`.
- `send_to`, out, N: crossbar destination mask.
- `send_en`, out, 1: crossbar send enable.
- `send_addr`, out, BADDR: remote write address.
- `send_word`, out, W: data word.
- `busy`, out, 1: a command is in progress.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- **IDLE**
  - `cmd_ready`=1.
  - A command is accepted when `cmd_valid` and `cmd_ready` are both high. On acceptance the engine latches `dest`, `src`, `dst` and `len`, and clears the issue counter.
  - If `cmd_len`=0 or `cmd_dest`=0, the engine issues no reads, pulses `done` in the next cycle and stays in IDLE.
  - Otherwise the engine goes to RUN.
- **RUN**
  - In each cycle with `hold`=0, the engine drives `mem_rd_en`=1 and `mem_rd_addr`=src+count (mod 2^BRADDR).
  - It pushes valid plus dst+count (mod 2^BADDR) into an RDLAT-deep delay line, then increments count.
  - After issuing the read for word len-1, the engine goes to DRAIN.
  - While `hold`=1, no read is issued and count holds. Reads already in flight still complete, because the crossbar has no backpressure.
- **DRAIN**
  - The engine waits until the delay line is empty, then returns to IDLE.
- **Send stage** (registered)
  - When a delay-line entry exits valid, the engine registers `send_en`=1, `send_to`=latched dest, `send_addr`=entry address and `send_word`=`mem_rd_word`.
  - Otherwise all four send outputs are 0.
- `done`=1 in the same cycle as the final `send_en`.
- `busy`=1 from the cycle after acceptance until the cycle of `done`, inclusive.
- `cmd_ready`=0 whenever the state is not IDLE.
- Arbitration is not this block's job: senders must not target the same destination in the same cycle, because the crossbar ORs colliding words together.

## Timing
- Reset (`clr_n`=0, asynchronous): state=IDLE, delay line cleared. All outputs are 0 except `cmd_ready`, which is 1.
- A read issued in cycle t produces `send_en` in cycle t+RDLAT+1.
- Command accepted at the edge ending cycle c:
  - first `mem_rd_en` in c+1;
  - first `send_en` in c+RDLAT+2;
  - with no hold, the last `send_en` and `done` fall in c+RDLAT+1+len;
  - `cmd_ready` returns in the cycle after `done`.
- Throughput is one word per cycle with no holds.
- The crossbar adds a further cycle before `recv_en`.
- `hold` changes take effect in the same cycle (combinational gate on issue). Holds stretch latency by the number of held RUN cycles.
- `clr_n` asserted mid-transfer: everything clears immediately, no `done` is produced, and in-flight reads are discarded.
- Counters wrap silently at 2^BRADDR and 2^BADDR.

## Configuration
- `INTERCONN_TX_STATS_EN` defined: adds output `stat_words` (32 bits). It counts cycles with `send_en`=1 since reset, saturates at 2^32-1, and is cleared by `clr_n`.
- Not defined: the port and counter are absent.

## Structure
- Package `interconn_pkg` holds:
  - the FSM state enum (IDLE/RUN/DRAIN);
  - default values for N, W, BADDR, BRADDR, BLEN and RDLAT, shared with the crossbar.
- Sub-module `interconn_tx_pipe` is the RDLAT-stage valid+address delay line, and reports an empty flag.

## Test plan
- **Reset:** hold `clr_n` low, then release it → all outputs 0, `cmd_ready`=1, `busy`=0.
- **Multicast transfer:** RDLAT=2, dest=8'h81, src=0x010, dst=0x200, len=4, memory returns data=address, accepted in cycle c →
  - `mem_rd_en` in c+1..c+4;
  - `send_en` in c+4..c+7 with `send_to`=8'h81;
  - `send_addr` 0x200..0x203 and `send_word` 0x10..0x13;
  - `done` in c+7.
- **Hold:** same command with `hold`=1 in c+2..c+3 → 2-cycle gap in `send_en`, all 4 words in order, `done` in c+9.
- **Degenerate commands:** len=0, then dest=0 → no `mem_rd_en` and no `send_en`; `done` in c+1; `cmd_ready`=1 in c+1.
- **Address wrap:** dst=0x7FFE, src=0x7FFF, len=4 → `send_addr` 0x7FFE, 0x7FFF, 0x0000, 0x0001; `mem_rd_addr` 0x7FFF, 0x0000, 0x0001, 0x0002.
- **Reset mid-transfer:** `clr_n` low during word 2 of a len=8 transfer → outputs 0 immediately, no `done`. A following len=2 command completes normally.
